// File: rtl/inferno_stick_decoder_if.sv
// Per-player control bundle: raw stick/pad inputs in, cabinet run/aim/trigger codes out.
interface inferno_stick_decoder_if;
    logic [15:0] analog_l;
    logic [15:0] analog_r;
    logic [3:0]  dpad;
    logic [3:0]  aim_btn;
    logic        trigger_btn;
    logic        aimfire_en;
    logic [3:0]  btn_run;
    logic [3:0]  btn_aim;
    logic        btn_trigger;

    modport master (
        output analog_l, analog_r, dpad, aim_btn, trigger_btn, aimfire_en,
        input  btn_run, btn_aim, btn_trigger
    );

    modport slave (
        input  analog_l, analog_r, dpad, aim_btn, trigger_btn, aimfire_en,
        output btn_run, btn_aim, btn_trigger
    );
endinterface

// File: rtl/inferno_stick_decoder.sv
// Stick/pad conditioning for one Inferno player: hysteresis, 45-degree
// diagonal mapping, debounce and the aim-fire trigger stretcher.
module inferno_stick_debounce #(
    parameter int CYC = 1024
) (
    input  logic       clock_12,
    input  logic       reset,
    input  logic [3:0] cand,
    output logic [3:0] code
);
    localparam int CW = $clog2(CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(CYC - 1);
    localparam logic [CW-1:0] MAX  = CW'(CYC);

    logic [3:0]    prev;
    logic [CW-1:0] cnt;

    // prev/cnt describe how long the candidate has held still
    always_ff @(posedge clock_12) begin
        if (reset) begin
            prev <= '0;
            cnt  <= '0;
            code <= '0;
        end else begin
            prev <= cand;
            if (cand != prev)
                cnt <= '0;
            else if (cnt != MAX)
                cnt <= cnt + CW'(1);
            if (cnt == LAST && prev != code)
                code <= prev;
        end
    end
endmodule

module inferno_stick_decoder #(
    parameter int THRESH_ON    = 24,
    parameter int THRESH_OFF   = 16,
    parameter int DEBOUNCE_CYC = 1024,
    parameter int HOLD_CYC     = 60000
) (
    input  logic clock_12,
    input  logic reset,
    inferno_stick_decoder_if.slave io
);
    typedef enum logic [1:0] {AX_CENTER, AX_POS, AX_NEG} axis_t;
    typedef enum logic [1:0] {TR_IDLE, TR_FIRE, TR_HOLD} trig_t;

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);
    localparam logic signed [8:0] ON_P  = 9'(THRESH_ON);
    localparam logic signed [8:0] ON_N  = -ON_P;
    localparam logic signed [8:0] OFF_P = 9'(THRESH_OFF);
    localparam logic signed [8:0] OFF_N = -OFF_P;

    function automatic axis_t step_axis(axis_t s, logic [7:0] raw);
        logic signed [8:0] v;
        v = $signed({raw[7], raw});
        step_axis = s;
        unique case (s)
            AX_CENTER: begin
                if (v > ON_P)
                    step_axis = AX_POS;
                else if (v < ON_N)
                    step_axis = AX_NEG;
            end
            AX_POS:  if (v < OFF_P) step_axis = AX_CENTER;
            AX_NEG:  if (v > OFF_N) step_axis = AX_CENTER;
            default: step_axis = AX_CENTER;
        endcase
    endfunction

    // {UR, DL, UL, DR}
    function automatic logic [3:0] diag(axis_t y, axis_t x);
        diag = {y == AX_NEG && x == AX_POS,
                y == AX_POS && x == AX_NEG,
                y == AX_NEG && x == AX_NEG,
                y == AX_POS && x == AX_POS};
    endfunction

    logic [15:0] al_q, ar_q;
    logic [3:0]  dpad_q, dpad_qq, aimb_q, aimb_qq;
    logic        trig_q, af_q, af_d;
    axis_t       lx, ly, rx, ry;
    logic [3:0]  run_cand, aim_cand, run_code, aim_code;
    trig_t       tr_state;
    logic [HW-1:0] hold_cnt;
    logic        trg;

    // buttons get a second stage so they line up with the classifiers
    always_ff @(posedge clock_12) begin
        if (reset) begin
            al_q    <= '0;
            ar_q    <= '0;
            dpad_q  <= '0;
            dpad_qq <= '0;
            aimb_q  <= '0;
            aimb_qq <= '0;
            trig_q  <= 1'b0;
            af_q    <= 1'b0;
            lx      <= AX_CENTER;
            ly      <= AX_CENTER;
            rx      <= AX_CENTER;
            ry      <= AX_CENTER;
        end else begin
            al_q    <= io.analog_l;
            ar_q    <= io.analog_r;
            dpad_q  <= io.dpad;
            dpad_qq <= dpad_q;
            aimb_q  <= io.aim_btn;
            aimb_qq <= aimb_q;
            trig_q  <= io.trigger_btn;
            af_q    <= io.aimfire_en;
            lx      <= step_axis(lx, al_q[7:0]);
            ly      <= step_axis(ly, al_q[15:8]);
            rx      <= step_axis(rx, ar_q[7:0]);
            ry      <= step_axis(ry, ar_q[15:8]);
        end
    end

    assign run_cand = (lx != AX_CENTER || ly != AX_CENTER) ?
                      diag(ly, lx) : dpad_qq;
    assign aim_cand = diag(ry, rx) | aimb_qq;

    inferno_stick_debounce #(.CYC(DEBOUNCE_CYC)) u_run_db (
        .clock_12 (clock_12),
        .reset    (reset),
        .cand     (run_cand),
        .code     (run_code)
    );

    inferno_stick_debounce #(.CYC(DEBOUNCE_CYC)) u_aim_db (
        .clock_12 (clock_12),
        .reset    (reset),
        .cand     (aim_cand),
        .code     (aim_code)
    );

    // manual mode or a mode toggle parks the FSM and passes the button through
    always_ff @(posedge clock_12) begin
        if (reset) begin
            tr_state <= TR_IDLE;
            hold_cnt <= '0;
            af_d     <= 1'b0;
            trg      <= 1'b0;
        end else begin
            af_d <= af_q;
            if (!af_q || !af_d) begin
                tr_state <= TR_IDLE;
                hold_cnt <= '0;
                trg      <= af_q ? 1'b0 : trig_q;
            end else begin
                unique case (tr_state)
                    TR_IDLE: begin
                        if (aim_code != '0) begin
                            tr_state <= TR_FIRE;
                            trg      <= 1'b1;
                        end else begin
                            trg <= 1'b0;
                        end
                    end
                    TR_FIRE: begin
                        trg <= 1'b1;
                        if (aim_code == '0) begin
                            tr_state <= TR_HOLD;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end
                    TR_HOLD: begin
                        if (aim_code != '0) begin
                            tr_state <= TR_FIRE;
                        end else if (hold_cnt == '0) begin
                            tr_state <= TR_IDLE;
                            trg      <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - HW'(1);
                        end
                    end
                    default: begin
                        tr_state <= TR_IDLE;
                        trg      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io.btn_run     = {run_code[2], run_code[0], run_code[1], run_code[3]};
    assign io.btn_aim     = {aim_code[2], aim_code[0], aim_code[1], aim_code[3]};
    assign io.btn_trigger = trg;
endmodule
